getbits_unit: RTL and testbench

//   Bit-reader stage directly downstream of the flush buffer in the MPEG decoder.

---
 rtl/getbits_unit_pkg.sv | 22 ++
 rtl/getbits_extract.sv | 28 ++
 rtl/getbits_unit.sv | 181 ++++++++++++++++++
 tb/tb_getbits_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/getbits_unit_pkg.sv
// Shared definitions for the MPEG bit-reader stage (getbits_unit).
//   state_t        : FSM states of getbits_unit
//   WIN_BITS       : width of the flush-buffer window
//   MAX_SINGLE_DEF : largest request served with one flush
//   SPLIT_HI_DEF   : bits consumed by the first flush of a split request
package getbits_unit_pkg;

  localparam int unsigned WIN_BITS       = 32;
  localparam int unsigned MAX_SINGLE_DEF = 24;
  localparam int unsigned SPLIT_HI_DEF   = 16;

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_INIT_WAIT = 3'd1,
    S_IDLE      = 3'd2,
    S_FLUSH1    = 3'd3,
    S_WAIT1     = 3'd4,
    S_FLUSH2    = 3'd5,
    S_WAIT2     = 3'd6
  } state_t;

endpackage

// File: rtl/getbits_extract.sv
// Combinational field extractor: right-aligns the top nbits of a
// left-aligned window.
//   window : in  32  left-aligned window, MSB = next stream bit
//   nbits  : in  6   field width 0..32 (33..63 gives 0)
//   field  : out 32  right-aligned field, upper (32-nbits) bits zero
module getbits_extract
  import getbits_unit_pkg::*;
(
  input  logic [WIN_BITS-1:0] window,
  input  logic [5:0]          nbits,
  output logic [WIN_BITS-1:0] field
);

  localparam logic [5:0] N_WIN = 6'(WIN_BITS);

  logic [5:0] shamt;

  // nbits == 0 gives a shift of 32, which clears the field completely.
  always_comb begin
    shamt = N_WIN - nbits;
    if (nbits > N_WIN) begin
      field = '0;
    end else begin
      field = window >> shamt;
    end
  end

endmodule

// File: rtl/getbits_unit.sv
// Bit-reader stage downstream of the flush buffer. Serves requests for the
// next 0..32 stream bits, issuing flush(N) to the flush buffer and waiting
// for its refill. Requests larger than MAX_SINGLE are split in two flushes.
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : in   request strobe (accepted when req_ready)
//   req_ready   : out  high only in IDLE
//   req_nbits   : in   6  bits requested, 0..32
//   req_peek    : in   1 = show bits without consuming
//   rsp_valid   : out  one-cycle response pulse
//   rsp_data    : out  32 right-aligned result
//   rsp_err     : out  illegal nbits flag
//   fb_valid    : out  flush strobe to the flush buffer
//   fb_N        : out  32 flush amount, held until refill done
//   fb_loading  : in   flush buffer refilling
//   fb_done     : in   flush buffer refill complete (level)
//   fb_ld_bfr   : in   32 current window
module getbits_unit
  import getbits_unit_pkg::*;
#(
  parameter int unsigned MAX_SINGLE = MAX_SINGLE_DEF,
  parameter int unsigned SPLIT_HI   = SPLIT_HI_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          req_nbits,
  input  logic                req_peek,
  output logic                rsp_valid,
  output logic [WIN_BITS-1:0] rsp_data,
  output logic                rsp_err,
  output logic                fb_valid,
  output logic [WIN_BITS-1:0] fb_N,
  input  logic                fb_loading,
  input  logic                fb_done,
  input  logic [WIN_BITS-1:0] fb_ld_bfr
);

  localparam logic [5:0] N_WIN = 6'(WIN_BITS);
  localparam logic [5:0] N_MAX = 6'(MAX_SINGLE);
  localparam logic [5:0] N_HI  = 6'(SPLIT_HI);

  state_t              state, state_next;
  logic [5:0]          nbits_q, nbits_next;
  logic [WIN_BITS-1:0] combine_q, combine_next;
  logic                fb_valid_next, rsp_valid_next, rsp_err_next;
  logic [WIN_BITS-1:0] fb_n_next, rsp_data_next;
  logic [WIN_BITS-1:0] req_field, lo_field;
  logic [5:0]          lo_bits;
  logic                flush_done;

  assign req_ready = (state == S_IDLE);
  assign lo_bits   = nbits_q - N_HI;

  // done is stale during the fb_valid cycle; the flush buffer clears it on that edge.
  assign flush_done = fb_done && !fb_loading && !fb_valid;

  getbits_extract u_req_field (
    .window (fb_ld_bfr),
    .nbits  (req_nbits),
    .field  (req_field)
  );

  getbits_extract u_lo_field (
    .window (fb_ld_bfr),
    .nbits  (lo_bits),
    .field  (lo_field)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      nbits_q   <= '0;
      combine_q <= '0;
      fb_valid  <= 1'b0;
      fb_N      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      nbits_q   <= nbits_next;
      combine_q <= combine_next;
      fb_valid  <= fb_valid_next;
      fb_N      <= fb_n_next;
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
      rsp_err   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state;
    nbits_next     = nbits_q;
    combine_next   = combine_q;
    fb_valid_next  = 1'b0;
    fb_n_next      = fb_N;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data;
    rsp_err_next   = rsp_err;

    case (state)
      S_INIT: begin
        fb_valid_next = 1'b1;
        fb_n_next     = '0;
        state_next    = S_INIT_WAIT;
      end

      S_INIT_WAIT: begin
        if (flush_done) state_next = S_IDLE;
      end

      S_IDLE: begin
        if (req_valid) begin
          if (req_nbits == 6'd0) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = '0;
            rsp_err_next   = 1'b0;
          end else if (req_nbits > N_WIN) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = '0;
            rsp_err_next   = 1'b1;
          end else if (req_peek) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = req_field;
            rsp_err_next   = 1'b0;
          end else if (req_nbits <= N_MAX) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = req_field;
            rsp_err_next   = 1'b0;
            fb_valid_next  = 1'b1;
            fb_n_next      = {{(WIN_BITS-6){1'b0}}, req_nbits};
            nbits_next     = req_nbits;
            state_next     = S_WAIT1;
          end else begin
            nbits_next   = req_nbits;
            combine_next = fb_ld_bfr >> (WIN_BITS - SPLIT_HI);
            state_next   = S_FLUSH1;
          end
        end
      end

      S_FLUSH1: begin
        fb_valid_next = 1'b1;
        fb_n_next     = {{(WIN_BITS-6){1'b0}}, N_HI};
        state_next    = S_WAIT1;
      end

      S_WAIT1: begin
        if (flush_done) begin
          if (nbits_q > N_MAX) begin
            // The low field is taken from the window after the first refill:
            // after the second flush the window has already moved past it.
            combine_next = (combine_q << lo_bits) | lo_field;
            state_next   = S_FLUSH2;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      S_FLUSH2: begin
        fb_valid_next = 1'b1;
        fb_n_next     = {{(WIN_BITS-6){1'b0}}, lo_bits};
        state_next    = S_WAIT2;
      end

      S_WAIT2: begin
        if (flush_done) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = combine_q;
          rsp_err_next   = 1'b0;
          state_next     = S_IDLE;
        end
      end

      default: state_next = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_getbits_unit.sv
module tb_getbits_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_nbits;
  logic        req_peek;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        fb_valid;
  logic [31:0] fb_N;
  logic        fb_loading;
  logic        fb_done;
  logic [31:0] fb_ld_bfr;

  always #5 clk = ~clk;

  getbits_unit #(.MAX_SINGLE(24), .SPLIT_HI(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_nbits  (req_nbits),
    .req_peek   (req_peek),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .fb_valid   (fb_valid),
    .fb_N       (fb_N),
    .fb_loading (fb_loading),
    .fb_done    (fb_done),
    .fb_ld_bfr  (fb_ld_bfr)
  );

  // ---------------- flush buffer model ----------------
  logic [7:0] strm [16] = '{8'h00, 8'h68, 8'h78, 8'h30, 8'h48, 8'h20, 8'ha0, 8'hc0,
                           8'h10, 8'he0, 8'h58, 8'h38, 8'hf0, 8'h08, 8'hc8, 8'h28};

  function automatic logic [31:0] win_at(input int p);
    logic [31:0] w;
    logic [7:0]  byt;
    int          b;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      b = p + i;
      if (b < 128) begin
        byt       = strm[b / 8];
        w[31 - i] = byt[7 - (b % 8)];
      end
    end
    return w;
  endfunction

  int ptr, pend_n, ld_cnt;

  always @(posedge clk) begin
    if (rst) begin
      ptr        <= 0;
      pend_n     <= 0;
      ld_cnt     <= 0;
      fb_loading <= 1'b0;
      fb_done    <= 1'b0;
      fb_ld_bfr  <= '0;
    end else if (fb_valid) begin
      pend_n     <= int'(fb_N);
      fb_loading <= 1'b1;
      fb_done    <= 1'b0;
      ld_cnt     <= 3;
    end else if (fb_loading) begin
      if (ld_cnt == 1) begin
        ptr        <= ptr + pend_n;
        fb_ld_bfr  <= win_at(ptr + pend_n);
        fb_loading <= 1'b0;
        fb_done    <= 1'b1;
      end else begin
        ld_cnt <= ld_cnt - 1;
      end
    end
  end

  // ---------------- monitors ----------------
  int flush_cnt = 0;
  int rsp_cnt   = 0;
  int overlap   = 0;
  int fl_n [64];

  always @(negedge clk) begin
    if (fb_valid) begin
      fl_n[flush_cnt % 64] <= int'(fb_N);
      flush_cnt            <= flush_cnt + 1;
      if (fb_loading) overlap <= overlap + 1;
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int c;
    c = 0;
    while (!req_ready && c < 500) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(req_ready), 32'd1);
  endtask

  task automatic boot();
    rst       = 1'b1;
    req_valid = 1'b0;
    req_peek  = 1'b0;
    req_nbits = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ready("boot_ready");
  endtask

  task automatic do_req(input int n, input bit pk,
                        output logic [31:0] d, output logic e, output int lat,
                        output logic rdy_after, output int nfl, output int fi);
    wait_ready("ready_before_req");
    fi        = flush_cnt;
    req_valid = 1'b1;
    req_nbits = 6'(n);
    req_peek  = pk;
    @(negedge clk);
    req_valid = 1'b0;
    req_peek  = 1'b0;
    rdy_after = req_ready;
    lat       = 1;
    while (!rsp_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    d = rsp_data;
    e = rsp_err;
    @(negedge clk);
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    nfl = flush_cnt - fi;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] d;
  logic        e;
  logic        ra;
  int          lat, nfl, fi, f0, r0, c;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_nbits = '0;
    req_peek  = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  rsp_data,       32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_fb_valid",  32'(fb_valid),  32'd0);
    check("rst_fb_N",      fb_N,           32'd0);

    // priming flush after reset release
    f0  = flush_cnt;
    rst = 1'b0;
    wait_ready("init_ready");
    @(negedge clk);
    check("init_flush_count", 32'(flush_cnt - f0), 32'd1);
    check("init_flush_N",     32'(fl_n[f0 % 64]),  32'd0);
    check("init_window",      fb_ld_bfr,           32'h00687830);

    // get 8 then get 12
    do_req(8, 1'b0, d, e, lat, ra, nfl, fi);
    check("get8_data",   d,            32'h00);
    check("get8_err",    32'(e),       32'd0);
    check("get8_lat",    32'(lat),     32'd1);
    check("get8_ready_drop", 32'(ra),  32'd0);
    check("get8_nflush", 32'(nfl),     32'd1);
    check("get8_N",      32'(fl_n[fi % 64]), 32'd8);
    do_req(12, 1'b0, d, e, lat, ra, nfl, fi);
    check("get12_data",  d,            32'h687);
    check("get12_N",     32'(fl_n[fi % 64]), 32'd12);

    // peeks do not consume
    boot();
    do_req(16, 1'b1, d, e, lat, ra, nfl, fi);
    check("peek16a_data",   d,        32'h0068);
    check("peek16a_nflush", 32'(nfl), 32'd0);
    check("peek16a_ready",  32'(ra),  32'd1);
    do_req(16, 1'b1, d, e, lat, ra, nfl, fi);
    check("peek16b_data",   d,        32'h0068);
    check("peek16b_nflush", 32'(nfl), 32'd0);
    do_req(16, 1'b0, d, e, lat, ra, nfl, fi);
    check("get16_data",     d,        32'h0068);
    check("get16_N",        32'(fl_n[fi % 64]), 32'd16);
    do_req(16, 1'b1, d, e, lat, ra, nfl, fi);
    check("peek16c_data",   d,        32'h7830);

    // split get of 32
    boot();
    do_req(32, 1'b0, d, e, lat, ra, nfl, fi);
    check("get32_data",   d,        32'h00687830);
    check("get32_err",    32'(e),   32'd0);
    check("get32_nflush", 32'(nfl), 32'd2);
    check("get32_N1",     32'(fl_n[fi % 64]),       32'd16);
    check("get32_N2",     32'(fl_n[(fi + 1) % 64]), 32'd16);
    check("get32_multicycle", 32'(lat > 8), 32'd1);
    check("get32_ready_drop", 32'(ra), 32'd0);

    // n = 0 and illegal n
    do_req(0, 1'b0, d, e, lat, ra, nfl, fi);
    check("n0_data",   d,        32'd0);
    check("n0_err",    32'(e),   32'd0);
    check("n0_lat",    32'(lat), 32'd1);
    check("n0_nflush", 32'(nfl), 32'd0);
    do_req(40, 1'b0, d, e, lat, ra, nfl, fi);
    check("n40_data",   d,        32'd0);
    check("n40_err",    32'(e),   32'd1);
    check("n40_lat",    32'(lat), 32'd1);
    check("n40_nflush", 32'(nfl), 32'd0);

    // single / split boundary
    boot();
    do_req(24, 1'b0, d, e, lat, ra, nfl, fi);
    check("get24_data",   d,        32'h006878);
    check("get24_nflush", 32'(nfl), 32'd1);
    check("get24_N",      32'(fl_n[fi % 64]), 32'd24);
    boot();
    do_req(25, 1'b0, d, e, lat, ra, nfl, fi);
    check("get25_data",   d,        32'h0000d0f0);
    check("get25_nflush", 32'(nfl), 32'd2);
    check("get25_N1",     32'(fl_n[fi % 64]),       32'd16);
    check("get25_N2",     32'(fl_n[(fi + 1) % 64]), 32'd9);
    boot();
    do_req(32, 1'b1, d, e, lat, ra, nfl, fi);
    check("peek32_data",   d,        32'h00687830);
    check("peek32_nflush", 32'(nfl), 32'd0);

    // reset during WAIT2 of a split get
    boot();
    fi        = flush_cnt;
    r0        = rsp_cnt;
    req_valid = 1'b1;
    req_nbits = 6'd32;
    req_peek  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    c = 0;
    while (flush_cnt < fi + 2 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("midrst_second_flush", 32'(flush_cnt - fi), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_fb_valid",  32'(fb_valid),  32'd0);
    check("midrst_fb_N",      fb_N,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("midrst_reprime_ready");
    check("midrst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    do_req(8, 1'b0, d, e, lat, ra, nfl, fi);
    check("midrst_get8_data", d, 32'h00);
    do_req(12, 1'b0, d, e, lat, ra, nfl, fi);
    check("midrst_get12_data", d, 32'h687);

    check("no_flush_while_loading", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
